// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - fetches a 32-word window (two 4x4 blocks) from a frame into a local buffer
// One read outstanding at a time; buffer is readable combinationally in every state.
module window_fetch #(
   parameter int BASE_ADDR  = 16,
   parameter int FRAME_COLS = 64,
   parameter int COL_OFS    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] current_address,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic [4:0]  rd_idx,
   output logic [31:0] rd_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  k_q, k_d;
   logic [31:0] base_q, base_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] buf_q [32];
   logic        wr_en;

   // Word k: bit 4 picks the 4-column block, bits 3:2 the row, bits 1:0 the column in the block.
   function automatic logic [31:0] word_addr(input logic [4:0] k, input logic [31:0] ofs);
      logic [31:0] row;
      logic [31:0] col;
      row = {30'd0, k[3:2]};
      col = 32'(COL_OFS) + {29'd0, k[4], 2'b00} + {30'd0, k[1:0]};
      return 32'(BASE_ADDR) + ((row * 32'(FRAME_COLS) + col + ofs) << 2);
   endfunction

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      base_d  = base_q;
      addr_d  = addr_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = current_address;
               k_d     = 5'd0;
               addr_d  = word_addr(5'd0, current_address);
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               wr_en = 1'b1;
               if (k_q == 5'd31) begin
                  state_d = DONE;
               end else begin
                  k_d     = k_q + 5'd1;
                  addr_d  = word_addr(k_q + 5'd1, base_q);
                  state_d = REQ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= 5'd0;
         base_q  <= 32'd0;
         addr_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            buf_q[i] <= 32'd0;
         end
      end else if (wr_en) begin
         buf_q[k_q] <= mem_rdata;
      end
   end

   assign busy     = (state_q == REQ) || (state_q == WAIT);
   assign done     = (state_q == DONE);
   assign mem_req  = (state_q == REQ);
   assign mem_addr = addr_q;
   assign rd_data  = buf_q[rd_idx];

endmodule

// File: tb/tb_window_fetch.sv
// tb/tb_window_fetch.sv - table-driven and randomized bench for window_fetch
module tb_window_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] current_address;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rd_idx;
   logic [31:0] rd_data;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] addr;
      int          gd;
      int          rd;
      bit          tie_gnt;
      bit          restart;
      bit          incdata;
   } vec_t;

   vec_t vecs[$];

   window_fetch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .current_address (current_address),
      .busy            (busy),
      .done            (done),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_gnt         (mem_gnt),
      .mem_rvalid      (mem_rvalid),
      .mem_rdata       (mem_rdata),
      .rd_idx          (rd_idx),
      .rd_data         (rd_data)
   );

   always #5 clk = ~clk;

   // Frame geometry: two 4x4 blocks side by side starting at column 4 of a 64-word-pitch frame.
   function automatic logic [31:0] model_addr(input logic [31:0] a, input int k);
      logic [31:0] blk, row, col, word;
      blk  = 32'(k / 16);
      row  = 32'((k / 4) % 4);
      col  = 32'd4 + 32'd4 * blk + 32'(k % 4);
      word = row * 32'd64 + col;
      return 32'd16 + 32'd4 * (word + a);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic check_buf_zero(input string nm);
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         chk(nm, i, rd_data, 32'd0);
      end
   endtask

   task automatic run_fetch(input vec_t v, output logic [31:0] obs [32], output logic [31:0] exp_buf [32]);
      int          cyc;
      logic [31:0] data;
      @(negedge clk);
      current_address = v.addr;
      start           = 1'b1;
      mem_gnt         = v.tie_gnt;
      @(posedge clk);
      #1;
      start           = 1'b0;
      current_address = $urandom;
      cyc             = 0;
      for (int k = 0; k < 32; k++) begin
         for (int i = 0; i <= v.gd; i++) begin
            @(negedge clk);
            chk("req_high", k, mem_req, 1);
            chk("busy_req", k, busy, 1);
            chk("addr", k, mem_addr, model_addr(v.addr, k));
            if (i == 0) obs[k] = mem_addr;
            mem_gnt = (i == v.gd) || v.tie_gnt;
            @(posedge clk);
            cyc++;
            #1;
            mem_gnt = v.tie_gnt;
         end
         data       = v.incdata ? 32'(k) + 32'hA0 : $urandom;
         exp_buf[k] = data;
         for (int j = 0; j <= v.rd; j++) begin
            @(negedge clk);
            chk("req_low_wait", k, mem_req, 0);
            chk("busy_wait", k, busy, 1);
            if (v.restart && k == 8 && j == 0) begin
               start           = 1'b1;
               current_address = $urandom;
            end
            if (j == v.rd) begin
               mem_rvalid = 1'b1;
               mem_rdata  = data;
            end
            @(posedge clk);
            cyc++;
            #1;
            mem_rvalid = 1'b0;
            start      = 1'b0;
            mem_rdata  = $urandom;
         end
      end
      @(negedge clk);
      chk("done_pulse", 0, done, 1);
      chk("busy_done", 0, busy, 0);
      chk("req_done", 0, mem_req, 0);
      @(posedge clk);
      cyc++;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 0, done, 0);
      chk("latency", 0, 32'(cyc), 32'(32 * (v.gd + v.rd + 2) + 1));
      // Stray handshakes while idle must not start a request or touch the buffer.
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_0000;
      @(negedge clk);
      chk("idle_req", 0, mem_req, 0);
      chk("idle_busy", 0, busy, 0);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         chk("buf", i, rd_data, exp_buf[i]);
      end
   endtask

   initial begin
      logic [31:0] obs [32];
      logic [31:0] eb [32];
      vec_t        v;

      vecs.push_back('{32'h0000_0000, 0, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{32'd100,       0, 0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{32'h0000_0000, 3, 4, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{32'h0000_1234, 1, 2, 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < 4; i++) begin
         v.addr    = $urandom;
         v.gd      = int'($urandom_range(0, 3));
         v.rd      = int'($urandom_range(0, 3));
         v.tie_gnt = 1'b0;
         v.restart = i[0];
         v.incdata = 1'b0;
         vecs.push_back(v);
      end

      rst_n           = 1'b0;
      start           = 1'b0;
      current_address = 32'd0;
      mem_gnt         = 1'b0;
      mem_rvalid      = 1'b0;
      mem_rdata       = 32'd0;
      rd_idx          = 5'd0;
      #1;
      chk("rst_busy", 0, busy, 0);
      chk("rst_done", 0, done, 0);
      chk("rst_req", 0, mem_req, 0);
      chk("rst_addr", 0, mem_addr, 0);
      check_buf_zero("rst_buf");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int n = 0; n < vecs.size(); n++) begin
         run_fetch(vecs[n], obs, eb);
         case (n)
            0: begin
               chk("v0_addr_k0", 0, obs[0], 32'd32);
               chk("v0_addr_k1", 1, obs[1], 32'd36);
               chk("v0_addr_k2", 2, obs[2], 32'd40);
               chk("v0_addr_k3", 3, obs[3], 32'd44);
               chk("v0_addr_k4", 4, obs[4], 32'd288);
               chk("v0_addr_k16", 16, obs[16], 32'd48);
               chk("v0_addr_k31", 31, obs[31], 32'd828);
            end
            1: begin
               chk("v1_first_addr", 0, obs[0], 32'd432);
               rd_idx = 5'd5;
               #1;
               chk("v1_rd5", 5, rd_data, 32'hA5);
            end
            2: chk("v2_wrap_addr", 0, obs[0], 32'd28);
            default: ;
         endcase
      end

      // Abandon a fetch at k=10, then a late rvalid must be ignored.
      @(negedge clk);
      current_address = 32'h40;
      start           = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         mem_gnt = 1'b1;
         @(posedge clk);
         #1;
         mem_gnt = 1'b0;
         @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hC0DE_0000 + 32'(k);
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
      end
      @(negedge clk);
      chk("abort_pre_addr", 10, mem_addr, model_addr(32'h40, 10));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 0, busy, 0);
      chk("abort_done", 0, done, 0);
      chk("abort_req", 0, mem_req, 0);
      chk("abort_addr", 0, mem_addr, 0);
      check_buf_zero("abort_buf");
      @(negedge clk);
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("late_busy", 0, busy, 0);
      check_buf_zero("late_buf");

      v.addr    = 32'h0000_0040;
      v.gd      = 1;
      v.rd      = 1;
      v.tie_gnt = 1'b0;
      v.restart = 1'b0;
      v.incdata = 1'b0;
      run_fetch(v, obs, eb);
      chk("refetch_k0", 0, obs[0], model_addr(32'h40, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
